// File: rtl/pwm_update_scheduler.sv
// Frame shadow bank, period-aligned commit to active PWM/dout registers,
// and host watchdog that blanks the PWM words when frames stop arriving.
module pwm_update_scheduler #(
  parameter int unsigned WDT_PERIODS = 40,
  parameter int unsigned WDT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        frame_end,
  input  logic        wr_stb,
  input  logic [5:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        pwm_at_top,
  output logic [15:0] pwm0,
  output logic [15:0] pwm1,
  output logic [15:0] pwm2,
  output logic [15:0] pwm3,
  output logic [9:0]  dout,
  output logic        zpolarity,
  output logic        commit_stb,
  output logic        wdt_fault,
  output logic [7:0]  status
);

  localparam int unsigned NLOW  = 9;   // byte addresses 0..8 stored whole
  localparam int unsigned NMASK = 10;  // addresses 0..9 tracked in the mask
  localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_PERIODS);
  localparam logic             WDT_ON    = (WDT_PERIODS != 0);

  typedef enum logic [1:0] {IDLE, FRAME, PENDING} state_e;

  state_e             state_q, state_d;
  logic [NMASK-1:0]   mask_q, mask_d, wr_hit;
  logic [7:0]         shadow_q [NLOW];
  logic [7:0]         shadow_d [NLOW];
  logic [2:0]         shadow_hi_q, shadow_hi_d;  // {zpolarity, dout[9:8]}
  logic [15:0]        pwm_q [4];
  logic [15:0]        pwm_d [4];
  logic [15:0]        pwm_vis_q [4];
  logic [15:0]        pwm_vis_d [4];
  logic [9:0]         dout_q, dout_d;
  logic               zpol_q, zpol_d;
  logic               commit_q, commit_d;
  logic [3:0]         short_q, short_d;
  logic [2:0]         super_q, super_d;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic               wdt_fault_q, wdt_fault_d;
  logic               do_commit;

  // Next-state: frame FSM, shadow writes, commit copy, watchdog and gating
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    shadow_d    = shadow_q;
    shadow_hi_d = shadow_hi_q;
    pwm_d       = pwm_q;
    dout_d      = dout_q;
    zpol_d      = zpol_q;
    commit_d    = 1'b0;
    short_d     = short_q;
    super_d     = super_q;
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fault_d = wdt_fault_q;
    wr_hit      = '0;
    do_commit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FRAME;
          mask_d  = '0;
        end
      end
      FRAME: begin
        if (wr_stb) begin
          for (int i = 0; i < int'(NLOW); i++) begin
            if (wr_addr == 6'(i)) begin
              shadow_d[i] = wr_data;
              wr_hit[i]   = 1'b1;
            end
          end
          if (wr_addr == 6'd9) begin
            shadow_hi_d = {wr_data[7], wr_data[1:0]};
            wr_hit[9]   = 1'b1;
          end
        end
        if (frame_start) begin
          mask_d = '0;
        end else if (frame_end) begin
          mask_d = mask_q | wr_hit;
          if ((mask_q | wr_hit) == {NMASK{1'b1}}) begin
            state_d = PENDING;
          end else begin
            state_d = IDLE;
            if (short_q != 4'hF) short_d = short_q + 4'd1;
          end
        end else begin
          mask_d = mask_q | wr_hit;
        end
      end
      PENDING: begin
        if (pwm_at_top) begin
          do_commit = 1'b1;
          if (frame_start) begin
            state_d = FRAME;
            mask_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (frame_start) begin
          state_d = FRAME;
          mask_d  = '0;
          if (super_q != 3'h7) super_d = super_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Copy the frozen shadow into the active registers
    if (do_commit) begin
      for (int k = 0; k < 4; k++) begin
        pwm_d[k] = {shadow_q[2*k+1], shadow_q[2*k]};
      end
      dout_d   = {shadow_hi_q[1:0], shadow_q[8]};
      zpol_d   = shadow_hi_q[2];
      commit_d = 1'b1;
    end

    // Watchdog: commit clears, each top counts up to the limit
    if (WDT_ON) begin
      if (do_commit) begin
        wdt_cnt_d   = '0;
        wdt_fault_d = 1'b0;
      end else if (pwm_at_top && (wdt_cnt_q < WDT_LIMIT)) begin
        wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
      end
      if (wdt_cnt_d == WDT_LIMIT) wdt_fault_d = 1'b1;
    end else begin
      wdt_cnt_d   = '0;
      wdt_fault_d = 1'b0;
    end

    // Visible PWM words are blanked while the watchdog is tripped
    for (int k = 0; k < 4; k++) begin
      pwm_vis_d[k] = wdt_fault_d ? 16'h0000 : pwm_d[k];
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      shadow_q    <= '{default: '0};
      shadow_hi_q <= '0;
      pwm_q       <= '{default: '0};
      pwm_vis_q   <= '{default: '0};
      dout_q      <= '0;
      zpol_q      <= 1'b0;
      commit_q    <= 1'b0;
      short_q     <= '0;
      super_q     <= '0;
      wdt_cnt_q   <= '0;
      wdt_fault_q <= WDT_ON;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      shadow_q    <= shadow_d;
      shadow_hi_q <= shadow_hi_d;
      pwm_q       <= pwm_d;
      pwm_vis_q   <= pwm_vis_d;
      dout_q      <= dout_d;
      zpol_q      <= zpol_d;
      commit_q    <= commit_d;
      short_q     <= short_d;
      super_q     <= super_d;
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fault_q <= wdt_fault_d;
    end
  end

  assign pwm0       = pwm_vis_q[0];
  assign pwm1       = pwm_vis_q[1];
  assign pwm2       = pwm_vis_q[2];
  assign pwm3       = pwm_vis_q[3];
  assign dout       = dout_q;
  assign zpolarity  = zpol_q;
  assign commit_stb = commit_q;
  assign wdt_fault  = wdt_fault_q;
  assign status     = {wdt_fault_q, super_q, short_q};

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench for pwm_update_scheduler with hand-computed expectations.
module tb_pwm_update_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_end = 1'b0;
  logic        wr_stb = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        pwm_at_top = 1'b0;
  logic [15:0] pwm0, pwm1, pwm2, pwm3;
  logic [9:0]  dout;
  logic        zpolarity, commit_stb, wdt_fault;
  logic [7:0]  status;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_update_scheduler #(.WDT_PERIODS(40), .WDT_W(8)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .pwm_at_top(pwm_at_top),
    .pwm0(pwm0), .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3), .dout(dout),
    .zpolarity(zpolarity), .commit_stb(commit_stb), .wdt_fault(wdt_fault),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    wr_stb = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic top();
    pwm_at_top = 1'b1; tick(); pwm_at_top = 1'b0;
  endtask

  // Writes addresses 0..9 with base+i (caller already in FRAME), then frame_end
  task automatic body(input logic [7:0] base, input logic fe_top);
    for (int i = 0; i < 10; i++) wr(6'(i), base + 8'(i));
    frame_end = 1'b1; pwm_at_top = fe_top;
    tick();
    frame_end = 1'b0; pwm_at_top = 1'b0;
  endtask

  initial begin
    // 1: reset, full frame, commit on top
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_pwm0", 32'(pwm0), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_zpol", 32'(zpolarity), 32'h0);
    check("rst_commit", 32'(commit_stb), 32'h0);
    check("rst_wdt", 32'(wdt_fault), 32'h1);
    check("rst_status", 32'(status), 32'h80);

    fs();
    for (int i = 0; i < 10; i++) wr(6'(i), 8'h11 * 8'(i + 1));
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t1_pre_commit", 32'(commit_stb), 32'h0);
    check("t1_pre_pwm0", 32'(pwm0), 32'h0);
    top();
    check("t1_commit", 32'(commit_stb), 32'h1);
    check("t1_pwm0", 32'(pwm0), 32'h2211);
    check("t1_pwm1", 32'(pwm1), 32'h4433);
    check("t1_pwm2", 32'(pwm2), 32'h6655);
    check("t1_pwm3", 32'(pwm3), 32'h8877);
    check("t1_dout", 32'(dout), 32'h299);
    check("t1_zpol", 32'(zpolarity), 32'h1);
    check("t1_wdt", 32'(wdt_fault), 32'h0);
    tick();
    check("t1_commit_width", 32'(commit_stb), 32'h0);

    // 2: incomplete frame is counted and never committed
    fs();
    for (int i = 0; i < 9; i++) wr(6'(i), 8'(i + 1));
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("t2_status", 32'(status), 32'h01);
    top();
    check("t2_no_commit", 32'(commit_stb), 32'h0);
    check("t2_pwm0_kept", 32'(pwm0), 32'h2211);
    check("t2_dout_kept", 32'(dout), 32'h299);

    // 3: supersede without top, then frame_start coincident with top
    fs();
    body(8'h30, 1'b0);
    fs();
    check("t3_superseded", 32'(status), 32'h11);
    check("t3_no_commit", 32'(commit_stb), 32'h0);
    body(8'h40, 1'b0);
    frame_start = 1'b1; pwm_at_top = 1'b1;
    tick();
    frame_start = 1'b0; pwm_at_top = 1'b0;
    check("t3_fs_top_commit", 32'(commit_stb), 32'h1);
    check("t3_fs_top_pwm0", 32'(pwm0), 32'h4140);
    check("t3_fs_top_status", 32'(status), 32'h11);
    body(8'h50, 1'b0);
    top();
    check("t3_new_commit", 32'(commit_stb), 32'h1);
    check("t3_new_pwm0", 32'(pwm0), 32'h5150);
    check("t3_new_dout", 32'(dout), 32'h158);
    check("t3_new_zpol", 32'(zpolarity), 32'h0);

    // 4: watchdog trips on the 40th top without a commit
    for (int i = 0; i < 39; i++) top();
    check("t4_wdt_39", 32'(wdt_fault), 32'h0);
    check("t4_pwm0_39", 32'(pwm0), 32'h5150);
    top();
    check("t4_wdt_40", 32'(wdt_fault), 32'h1);
    check("t4_pwm0_gated", 32'(pwm0), 32'h0);
    check("t4_pwm3_gated", 32'(pwm3), 32'h0);
    check("t4_dout_held", 32'(dout), 32'h158);
    check("t4_status", 32'(status), 32'h91);
    fs();
    body(8'h60, 1'b0);
    top();
    check("t4_recover_wdt", 32'(wdt_fault), 32'h0);
    check("t4_recover_pwm0", 32'(pwm0), 32'h6160);
    check("t4_recover_commit", 32'(commit_stb), 32'h1);

    // 5: addr 12 is ignored; frame_end with top defers the commit
    fs();
    for (int i = 0; i < 9; i++) wr(6'(i), 8'hA0 + 8'(i));
    wr(6'd12, 8'hFF);
    frame_end = 1'b1; tick(); frame_end = 1'b0;
    check("t5_addr12_no_mask", 32'(status), 32'h12);
    fs();
    for (int i = 0; i < 10; i++) wr(6'(i), 8'h70 + 8'(i));
    wr(6'd12, 8'hFF);
    frame_end = 1'b1; pwm_at_top = 1'b1;
    tick();
    frame_end = 1'b0; pwm_at_top = 1'b0;
    check("t5_fe_top_no_commit", 32'(commit_stb), 32'h0);
    check("t5_fe_top_pwm0", 32'(pwm0), 32'h6160);
    top();
    check("t5_commit", 32'(commit_stb), 32'h1);
    check("t5_pwm0", 32'(pwm0), 32'h7170);
    check("t5_pwm2_clean", 32'(pwm2), 32'h7574);
    check("t5_pwm3", 32'(pwm3), 32'h7776);
    check("t5_dout", 32'(dout), 32'h178);

    // 6: reset while PENDING drops the frame
    fs();
    body(8'h80, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_pwm0", 32'(pwm0), 32'h0);
    check("t6_dout", 32'(dout), 32'h0);
    check("t6_zpol", 32'(zpolarity), 32'h0);
    check("t6_wdt", 32'(wdt_fault), 32'h1);
    check("t6_status", 32'(status), 32'h80);
    top();
    check("t6_no_commit", 32'(commit_stb), 32'h0);
    check("t6_pwm1", 32'(pwm1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_update_scheduler.md
Name: pwm_update_scheduler

Overview:
- Sits between the SPI byte engine and the PWM/dout output stage in the Pluto servo firmware.
- Collects the per-frame command bytes into a shadow bank and validates that the frame is complete.
- Commits a complete frame to the active PWM/dout registers only at a PWM period boundary, so duty cycles never change mid-period.
- Runs a host watchdog that forces all PWM words to zero when the host stops sending valid frames.

Parameters:
- WDT_PERIODS, 40, number of PWM periods without a commit before the watchdog trips (about 2 ms at 20 kHz); 0 disables the watchdog.
- WDT_W, 8, watchdog counter width; WDT_PERIODS must be < 2^WDT_W.

Ports:
- clk  in  1  system clock (40 MHz).
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  1-cycle pulse at SSEL falling edge.
- frame_end  in  1  1-cycle pulse at SSEL rising edge.
- wr_stb  in  1  1-cycle pulse: a received byte is valid.
- wr_addr  in  6  byte index within the frame.
- wr_data  in  8  received byte.
- pwm_at_top  in  1  1-cycle pulse at the PWM counter wrap.
- pwm0..pwm3  out  16 each  active PWM command words.
- dout  out  10  active digital outputs.
- zpolarity  out  1  active index-polarity bit.
- commit_stb  out  1  1-cycle pulse, high in the cycle the active registers first show new values.
- wdt_fault  out  1  watchdog tripped / no valid commit since reset.
- status  out  8  {wdt_fault, superseded[2:0], short_frames[3:0]}.

Behaviour:
- Address map (shadow bank):
  - 0/1 = pwm0[7:0]/[15:8]; 2/3 = pwm1; 4/5 = pwm2; 6/7 = pwm3.
  - 8 = dout[7:0].
  - 9 = dout[9:8] <= wr_data[1:0] and zpolarity <= wr_data[7].
  - addr >= 10 is ignored (no shadow write, no mask bit).
- A 10-bit written-mask holds one bit per address 0..9.
- Reset values:
  - state IDLE; mask 0; shadow 0.
  - pwm0..3 = 0; dout = 0; zpolarity = 0; commit_stb = 0.
  - wdt counter = 0; short_frames = 0; superseded = 0.
  - wdt_fault = 1 if WDT_PERIODS != 0, else 0.
- State IDLE:
  - frame_start -> FRAME, mask cleared.
  - wr_stb and frame_end are ignored.
- State FRAME:
  - wr_stb writes the shadow byte and sets its mask bit; rewriting an address is allowed, last write wins.
  - frame_start -> stay in FRAME, mask cleared (frame restarted).
  - frame_end with mask == 10'h3FF -> PENDING.
  - frame_end with an incomplete mask -> IDLE, short_frames += 1 (saturates at 15).
  - A wr_stb in the same cycle as frame_end is applied and counted in the mask check.
  - pwm_at_top is ignored, including when it coincides with frame_end; the commit waits for the next pwm_at_top.
- State PENDING:
  - pwm_at_top -> copy the shadow to the active registers at the next edge, commit_stb = 1 for that one cycle -> IDLE.
  - frame_start without pwm_at_top -> FRAME, mask cleared, pending frame discarded, superseded += 1 (saturates at 7).
  - frame_start together with pwm_at_top -> commit happens, then FRAME (mask cleared); superseded unchanged.
  - wr_stb is ignored; shadow stays frozen.
- Latency: the active outputs change exactly 1 clk after the pwm_at_top cycle that triggers the commit. commit_stb is registered and aligned with the new values.
- Watchdog (only when WDT_PERIODS != 0):
  - A commit clears the counter to 0 and clears wdt_fault.
  - Otherwise each pwm_at_top increments the counter, saturating at WDT_PERIODS.
  - When the counter reaches WDT_PERIODS, wdt_fault is set.
  - Commit and counter increment in the same cycle: the commit wins (counter = 0).
- Fault output gating:
  - While wdt_fault = 1, pwm0..pwm3 read as 16'h0000; dout and zpolarity are not gated.
  - The stored active values are retained but invisible; they are overwritten at the next commit anyway.
- rst asserted mid-frame or while PENDING: all state returns to reset values on that edge; no commit occurs.

Test Plan:
1. Reset, then a full frame writing addr 0..9 = 8'h11,8'h22,...,8'hAA, frame_end, pwm_at_top 5 cycles later -> 1 clk after the top: pwm0 = 16'h2211, pwm3 = 16'h8877, dout = 10'h299 ({2'b10, 8'h99} from addr 9 = 8'hAA, addr 8 = 8'h99), zpolarity = 1, commit_stb high for exactly 1 cycle, wdt_fault falls 0.
2. Frame writing addr 0..8 only, then frame_end -> state IDLE, status[3:0] = 1, no commit on later tops, previous active values unchanged.
3. Complete frame -> PENDING, then frame_start with no top -> status[6:4] = 1. Repeat the same with frame_start coincident with pwm_at_top -> commit_stb = 1, superseded unchanged, new frame accepted.
4. WDT_PERIODS = 40: commit, then 39 tops -> wdt_fault = 0; 40th top -> wdt_fault = 1 and pwm0..3 read 0 while dout is held; next valid commit -> wdt_fault = 0 and new pwm values visible.
5. frame_end coincident with pwm_at_top on a complete frame -> no commit on that top; commit on the next top. Also check that wr_stb with addr 12 changes neither shadow nor mask.
6. rst pulsed while PENDING -> outputs 0, wdt_fault = 1, the following pwm_at_top produces no commit_stb.
